// File: rtl/rs_pkg.sv
// rs_pkg: default widths and the entry record shared by reservation_station and rs_select
package rs_pkg;
  localparam int RS_SIZE_D = 4;
  localparam int DATA_W_D = 32;
  localparam int TAG_W_D = 4;
  localparam int OP_W_D = 6;
  localparam int AGE_W = $clog2(RS_SIZE_D);
  typedef struct packed {
    logic busy;
    logic [OP_W_D-1:0] op;
    logic [TAG_W_D-1:0] dest_tag, q1, q2;
    logic [DATA_W_D-1:0] v1, v2;
    logic r1, r2;
    logic [AGE_W-1:0] age;
  } rs_entry_t;
endpackage

// File: rtl/rs_select.sv
// rs_select: one-hot pick among req (lowest index, or oldest age with lowest-index tiebreak when RS_AGE_SELECT_EN); ports req/age in, grant/valid out
module rs_select #(
  parameter int N = 4,
  parameter int AW = 2
) (
  input  logic [N-1:0]         req,
  input  logic [N-1:0][AW-1:0] age,
  output logic [N-1:0]         grant,
  output logic                 valid
);
  assign valid = |req;
`ifdef RS_AGE_SELECT_EN
  logic [AW-1:0] best;
  logic found;
  always_comb begin
    grant = '0;
    best = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++)
      if (req[i] && (!found || age[i] > best)) begin
        grant = '0;
        grant[i] = 1'b1;
        best = age[i];
        found = 1'b1;
      end
  end
`else
  logic unused_age;
  assign unused_age = ^age;
  assign grant = req & (~req + 1'b1);
`endif
endmodule

// File: rtl/reservation_station.sv
// reservation_station: holds renamed ops until operands arrive via CDB, issues one per cycle to an FU over valid/ready, raises stall when full; ports clk, reset (sync active-low), flush, dispatch_*, stall, cdb_*, issue_*; RS_AGE_SELECT_EN selects oldest-first issue
module reservation_station
  import rs_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_D,
  parameter int DATA_WIDTH = DATA_W_D,
  parameter int TAG_WIDTH = TAG_W_D,
  parameter int OP_WIDTH = OP_W_D
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  dispatch_valid,
  input  logic [OP_WIDTH-1:0]   dispatch_op,
  input  logic [TAG_WIDTH-1:0]  dispatch_dest_tag,
  input  logic                  dispatch_src1_ready,
  input  logic [DATA_WIDTH-1:0] dispatch_src1_val,
  input  logic [TAG_WIDTH-1:0]  dispatch_src1_tag,
  input  logic                  dispatch_src2_ready,
  input  logic [DATA_WIDTH-1:0] dispatch_src2_val,
  input  logic [TAG_WIDTH-1:0]  dispatch_src2_tag,
  output logic                  stall,
  input  logic                  cdb_valid,
  input  logic [TAG_WIDTH-1:0]  cdb_tag,
  input  logic [DATA_WIDTH-1:0] cdb_data,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [OP_WIDTH-1:0]   issue_op,
  output logic [DATA_WIDTH-1:0] issue_a,
  output logic [DATA_WIDTH-1:0] issue_b,
  output logic [TAG_WIDTH-1:0]  issue_dest_tag
);
  rs_entry_t ent [RS_SIZE];
  rs_entry_t new_ent;
  logic [RS_SIZE-1:0] busy, req, grant, alloc;
  logic [RS_SIZE-1:0][AGE_W-1:0] age;
  logic sel_valid, accept, load, byp1, byp2;
  logic [OP_WIDTH-1:0] s_op;
  logic [DATA_WIDTH-1:0] s_a, s_b;
  logic [TAG_WIDTH-1:0] s_tag;
  rs_select #(.N(RS_SIZE), .AW(AGE_W)) u_sel (.req(req), .age(age), .grant(grant), .valid(sel_valid));
  always_comb begin
    busy = '0;
    req = '0;
    age = '0;
    s_op = '0;
    s_a = '0;
    s_b = '0;
    s_tag = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      busy[i] = ent[i].busy;
      req[i] = ent[i].busy && ent[i].r1 && ent[i].r2;
      age[i] = ent[i].age;
      if (grant[i]) begin
        s_op = ent[i].op;
        s_a = ent[i].v1;
        s_b = ent[i].v2;
        s_tag = ent[i].dest_tag;
      end
    end
  end
  assign stall = &busy;
  assign alloc = ~busy & (busy + 1'b1);
  assign accept = dispatch_valid && !stall && !flush;
  assign load = !issue_valid || issue_ready;
  assign byp1 = !dispatch_src1_ready && cdb_valid && cdb_tag == dispatch_src1_tag;
  assign byp2 = !dispatch_src2_ready && cdb_valid && cdb_tag == dispatch_src2_tag;
  assign new_ent = '{busy: 1'b1, op: dispatch_op, dest_tag: dispatch_dest_tag,
                     q1: dispatch_src1_tag, q2: dispatch_src2_tag,
                     v1: dispatch_src1_ready ? dispatch_src1_val : cdb_data,
                     v2: dispatch_src2_ready ? dispatch_src2_val : cdb_data,
                     r1: dispatch_src1_ready || byp1, r2: dispatch_src2_ready || byp2,
                     age: '0};
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
      issue_valid <= 1'b0;
      issue_op <= '0;
      issue_a <= '0;
      issue_b <= '0;
      issue_dest_tag <= '0;
    end else if (flush) begin
      for (int i = 0; i < RS_SIZE; i++) ent[i].busy <= 1'b0;
      issue_valid <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (load && grant[i]) ent[i].busy <= 1'b0;
        else if (accept && alloc[i]) ent[i] <= new_ent;
        else if (ent[i].busy) begin
          if (cdb_valid && !ent[i].r1 && ent[i].q1 == cdb_tag) begin
            ent[i].v1 <= cdb_data;
            ent[i].r1 <= 1'b1;
          end
          if (cdb_valid && !ent[i].r2 && ent[i].q2 == cdb_tag) begin
            ent[i].v2 <= cdb_data;
            ent[i].r2 <= 1'b1;
          end
`ifdef RS_AGE_SELECT_EN
          if (accept && ent[i].age != '1) ent[i].age <= ent[i].age + 1'b1;
`endif
        end
      end
      if (load) begin
        issue_valid <= sel_valid;
        if (sel_valid) begin
          issue_op <= s_op;
          issue_a <= s_a;
          issue_b <= s_b;
          issue_dest_tag <= s_tag;
        end
      end
    end
  end
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed stimulus with a slot-level reference model checked every cycle plus literal spot checks
module tb_reservation_station;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, flush, dispatch_valid, dispatch_src1_ready, dispatch_src2_ready;
  logic [5:0] dispatch_op;
  logic [3:0] dispatch_dest_tag, dispatch_src1_tag, dispatch_src2_tag, cdb_tag, issue_dest_tag;
  logic [31:0] dispatch_src1_val, dispatch_src2_val, cdb_data, issue_a, issue_b;
  logic stall, cdb_valid, issue_valid, issue_ready;
  logic [5:0] issue_op;
  reservation_station dut (
    .clk(clk), .reset(reset), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_op(dispatch_op), .dispatch_dest_tag(dispatch_dest_tag),
    .dispatch_src1_ready(dispatch_src1_ready), .dispatch_src1_val(dispatch_src1_val), .dispatch_src1_tag(dispatch_src1_tag),
    .dispatch_src2_ready(dispatch_src2_ready), .dispatch_src2_val(dispatch_src2_val), .dispatch_src2_tag(dispatch_src2_tag),
    .stall(stall), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_a(issue_a), .issue_b(issue_b), .issue_dest_tag(issue_dest_tag)
  );
  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  bit mb [4];
  bit mr1 [4];
  bit mr2 [4];
  int mage [4];
  logic [5:0] mop [4];
  logic [3:0] mtag [4];
  logic [3:0] mq1 [4];
  logic [3:0] mq2 [4];
  logic [31:0] mv1 [4];
  logic [31:0] mv2 [4];
  bit miv = 1'b0;
  logic [5:0] miop = '0;
  logic [31:0] mia = '0;
  logic [31:0] mib = '0;
  logic [3:0] mitag = '0;
  function automatic void cmp(string n, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, req);
    end
  endfunction
  function automatic bit m_full();
    return mb[0] && mb[1] && mb[2] && mb[3];
  endfunction
  always @(posedge clk) begin : model
    int sel, f;
    bit acc;
    if (!reset) begin
      for (int i = 0; i < 4; i++) mb[i] = 1'b0;
      miv = 1'b0; miop = '0; mia = '0; mib = '0; mitag = '0;
    end else if (flush) begin
      for (int i = 0; i < 4; i++) mb[i] = 1'b0;
      miv = 1'b0;
    end else begin
      sel = -1;
      for (int i = 0; i < 4; i++)
        if (mb[i] && mr1[i] && mr2[i]) begin
`ifdef RS_AGE_SELECT_EN
          if (sel < 0 || mage[i] > mage[sel]) sel = i;
`else
          if (sel < 0) sel = i;
`endif
        end
      f = -1;
      for (int i = 0; i < 4; i++) if (!mb[i] && f < 0) f = i;
      acc = dispatch_valid && f >= 0;
      for (int i = 0; i < 4; i++)
        if (mb[i]) begin
          if (cdb_valid && !mr1[i] && mq1[i] == cdb_tag) begin mv1[i] = cdb_data; mr1[i] = 1'b1; end
          if (cdb_valid && !mr2[i] && mq2[i] == cdb_tag) begin mv2[i] = cdb_data; mr2[i] = 1'b1; end
          if (acc && mage[i] < 3) mage[i]++;
        end
      if (!miv || issue_ready) begin
        miv = sel >= 0;
        if (sel >= 0) begin
          miop = mop[sel]; mia = mv1[sel]; mib = mv2[sel]; mitag = mtag[sel];
          mb[sel] = 1'b0;
        end
      end
      if (acc) begin
        mb[f] = 1'b1; mage[f] = 0; mop[f] = dispatch_op; mtag[f] = dispatch_dest_tag;
        mq1[f] = dispatch_src1_tag; mq2[f] = dispatch_src2_tag;
        mr1[f] = dispatch_src1_ready || (cdb_valid && cdb_tag == dispatch_src1_tag);
        mr2[f] = dispatch_src2_ready || (cdb_valid && cdb_tag == dispatch_src2_tag);
        mv1[f] = dispatch_src1_ready ? dispatch_src1_val : cdb_data;
        mv2[f] = dispatch_src2_ready ? dispatch_src2_val : cdb_data;
      end
    end
  end
  always @(negedge clk)
    if (chk_en) begin
      cmp("m_stall", {31'b0, stall}, {31'b0, m_full()});
      cmp("m_iv", {31'b0, issue_valid}, {31'b0, miv});
      cmp("m_op", {26'b0, issue_op}, {26'b0, miop});
      cmp("m_a", issue_a, mia);
      cmp("m_b", issue_b, mib);
      cmp("m_tag", {28'b0, issue_dest_tag}, {28'b0, mitag});
    end
  task automatic idle();
    dispatch_valid = 1'b0; cdb_valid = 1'b0;
  endtask
  task automatic disp(input logic [5:0] op, input logic [3:0] dt,
                      input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                      input logic r2, input logic [31:0] v2, input logic [3:0] t2);
    dispatch_valid = 1'b1; dispatch_op = op; dispatch_dest_tag = dt;
    dispatch_src1_ready = r1; dispatch_src1_val = v1; dispatch_src1_tag = t1;
    dispatch_src2_ready = r2; dispatch_src2_val = v2; dispatch_src2_tag = t2;
  endtask
  task automatic cdb(input logic [3:0] t, input logic [31:0] d);
    cdb_valid = 1'b1; cdb_tag = t; cdb_data = d;
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  initial begin
    reset = 1'b0; flush = 1'b0; issue_ready = 1'b1;
    disp(0, 0, 0, 0, 0, 0, 0, 0); idle(); cdb_tag = 0; cdb_data = 0;
    repeat (2) tick();
    cmp("rst_iv", {31'b0, issue_valid}, 0);
    cmp("rst_stall", {31'b0, stall}, 0);
    cmp("rst_a", issue_a, 0);
    reset = 1'b1; chk_en = 1'b1;
    disp(6'h01, 4'd3, 1, 32'd5, 0, 1, 32'd7, 0);
    tick(); idle();
    cmp("t1_early", {31'b0, issue_valid}, 0);
    tick();
    cmp("t1_iv", {31'b0, issue_valid}, 1);
    cmp("t1_a", issue_a, 5);
    cmp("t1_b", issue_b, 7);
    cmp("t1_tag", {28'b0, issue_dest_tag}, 3);
    cmp("t1_op", {26'b0, issue_op}, 1);
    tick();
    cmp("t1_empty", {31'b0, issue_valid}, 0);
    disp(6'h02, 4'd4, 0, 0, 4'd9, 1, 32'd3, 0);
    tick(); idle();
    tick();
    cmp("t2_wait", {31'b0, issue_valid}, 0);
    cdb(4'd9, 32'hAA);
    tick(); idle();
    cmp("t2_c1", {31'b0, issue_valid}, 0);
    tick();
    cmp("t2_iv", {31'b0, issue_valid}, 1);
    cmp("t2_a", issue_a, 32'hAA);
    cmp("t2_b", issue_b, 3);
    tick();
    disp(6'h03, 4'd5, 1, 32'd1, 0, 0, 0, 4'd6);
    cdb(4'd6, 32'h55);
    tick(); idle();
    cmp("t3_early", {31'b0, issue_valid}, 0);
    tick();
    cmp("t3_iv", {31'b0, issue_valid}, 1);
    cmp("t3_b", issue_b, 32'h55);
    tick();
    for (int k = 0; k < 4; k++) begin
      disp(6'h04, 4'(8 + k), 0, 0, 4'(10 + k), 1, 32'(k), 0);
      tick();
    end
    cmp("t4_full", {31'b0, stall}, 1);
    disp(6'h07, 4'd15, 1, 32'd9, 0, 1, 32'd9, 0);
    tick(); idle();
    cmp("t4_ignored", {31'b0, stall}, 1);
    cmp("t4_noiss", {31'b0, issue_valid}, 0);
    cdb(4'd11, 32'hBB);
    tick(); idle();
    cmp("t4_still", {31'b0, stall}, 1);
    tick();
    cmp("t4_iv", {31'b0, issue_valid}, 1);
    cmp("t4_a", issue_a, 32'hBB);
    cmp("t4_tag", {28'b0, issue_dest_tag}, 9);
    cmp("t4_unstall", {31'b0, stall}, 0);
    issue_ready = 1'b0; flush = 1'b1;
    cdb(4'd10, 32'hCC);
    disp(6'h08, 4'd1, 1, 32'd2, 0, 1, 32'd2, 0);
    tick(); flush = 1'b0; idle(); issue_ready = 1'b1;
    cmp("t6_iv", {31'b0, issue_valid}, 0);
    cmp("t6_stall", {31'b0, stall}, 0);
    repeat (3) begin
      tick();
      cmp("t6_quiet", {31'b0, issue_valid}, 0);
    end
    issue_ready = 1'b0;
    disp(6'h05, 4'd1, 1, 32'h11, 0, 1, 32'h12, 0);
    tick();
    disp(6'h06, 4'd2, 1, 32'h21, 0, 1, 32'h22, 0);
    tick(); idle();
    cmp("t5_first", issue_a, 32'h11);
    repeat (3) begin
      tick();
      cmp("t5_hold_iv", {31'b0, issue_valid}, 1);
      cmp("t5_hold_a", issue_a, 32'h11);
      cmp("t5_hold_op", {26'b0, issue_op}, 5);
    end
    issue_ready = 1'b1;
    tick();
    cmp("t5_second_iv", {31'b0, issue_valid}, 1);
    cmp("t5_second_a", issue_a, 32'h21);
    cmp("t5_second_tag", {28'b0, issue_dest_tag}, 2);
    tick();
    cmp("t5_done", {31'b0, issue_valid}, 0);
    disp(6'h09, 4'd7, 1, 32'd4, 0, 0, 0, 4'd12);
    tick(); idle(); reset = 1'b0;
    tick(); reset = 1'b1;
    cmp("rst2_iv", {31'b0, issue_valid}, 0);
    cmp("rst2_stall", {31'b0, stall}, 0);
    cdb(4'd12, 32'h77);
    tick(); idle();
    repeat (2) tick();
    cmp("rst2_quiet", {31'b0, issue_valid}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
